// File: rtl/ir_sensor_intf_if.sv
// ir_sensor_intf_if: handshake between the IR-sensor sequencer and the
// external SPI A2D master.
//   a2d_strt      : one-cycle conversion request (sequencer -> A2D)
//   a2d_chnl      : channel being converted, held until the complete
//   a2d_cnv_cmplt : one-cycle conversion-done pulse (A2D -> sequencer)
//   a2d_res       : 12-bit result, valid while a2d_cnv_cmplt is high
// master = sequencer side, slave = A2D side.
interface ir_sensor_intf_if;
  logic        a2d_strt;
  logic [2:0]  a2d_chnl;
  logic        a2d_cnv_cmplt;
  logic [11:0] a2d_res;

  modport master (
    output a2d_strt,
    output a2d_chnl,
    input  a2d_cnv_cmplt,
    input  a2d_res
  );

  modport slave (
    input  a2d_strt,
    input  a2d_chnl,
    output a2d_cnv_cmplt,
    output a2d_res
  );
endinterface

// File: rtl/ir_sensor_intf.sv
// ir_sensor_intf: sequences the IR emitter and the SPI A2D through eight
// channels (R0..R3 then L0..L3), latches the results and publishes them as
// one coherent set with a single-cycle IR_vld strobe.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : sweep enable, only looked at while idle
//   a2d (master)    : A2D request/complete handshake (see ir_sensor_intf_if)
//   IR_en           : IR emitter enable, high for the whole sweep
//   IR_R0..IR_L3    : latched readings, updated only with IR_vld
//   IR_vld          : one-cycle strobe, new readings are coherent
module ir_sensor_intf #(
  parameter int unsigned SETTLE_CYCLES  = 4096,
  parameter int unsigned HOLDOFF_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  ir_sensor_intf_if.master    a2d,
  output logic                IR_en,
  output logic [11:0]         IR_R0,
  output logic [11:0]         IR_R1,
  output logic [11:0]         IR_R2,
  output logic [11:0]         IR_R3,
  output logic [11:0]         IR_L0,
  output logic [11:0]         IR_L1,
  output logic [11:0]         IR_L2,
  output logic [11:0]         IR_L3,
  output logic                IR_vld
);

  localparam int unsigned TMAX = (SETTLE_CYCLES > HOLDOFF_CYCLES) ?
                                 SETTLE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_TC = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_TC   = TW'(HOLDOFF_CYCLES - 1);

  // START is never occupied: the request is issued straight from the
  // SETTLE/WAIT transition into the registered a2d_strt.
  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, HOLD} state_t;

  state_t        state_q, state_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic [2:0]    idx_q, idx_nxt;
  logic          strt_q, strt_nxt;
  logic          ir_en_nxt;
  logic          vld_nxt;
  logic          cap;
  logic          pub;
  logic [11:0]   shadow [0:6];

  assign a2d.a2d_strt = strt_q;
  assign a2d.a2d_chnl = idx_q;

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    idx_nxt   = idx_q;
    strt_nxt  = 1'b0;
    ir_en_nxt = IR_en;
    vld_nxt   = 1'b0;
    cap       = 1'b0;
    pub       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          ir_en_nxt = 1'b1;
          timer_nxt = '0;
          idx_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_q == SETTLE_TC) begin
          strt_nxt  = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT;
        end else begin
          timer_nxt = timer_q + 1'b1;
        end
      end
      WAIT: begin
        if (a2d.a2d_cnv_cmplt) begin
          if (idx_q != 3'd7) begin
            cap      = 1'b1;
            idx_nxt  = idx_q + 3'd1;
            strt_nxt = 1'b1;
          end else begin
            // last channel bypasses the shadow and goes out with the rest
            pub       = 1'b1;
            vld_nxt   = 1'b1;
            ir_en_nxt = 1'b0;
            timer_nxt = '0;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (timer_q == HOLD_TC) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      strt_q  <= 1'b0;
      IR_en   <= 1'b0;
      IR_vld  <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) begin
        shadow[i] <= '0;
      end
      IR_R0 <= '0;
      IR_R1 <= '0;
      IR_R2 <= '0;
      IR_R3 <= '0;
      IR_L0 <= '0;
      IR_L1 <= '0;
      IR_L2 <= '0;
      IR_L3 <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      idx_q   <= idx_nxt;
      strt_q  <= strt_nxt;
      IR_en   <= ir_en_nxt;
      IR_vld  <= vld_nxt;
      if (cap) begin
        shadow[idx_q] <= a2d.a2d_res;
      end
      if (pub) begin
        IR_R0 <= shadow[0];
        IR_R1 <= shadow[1];
        IR_R2 <= shadow[2];
        IR_R3 <= shadow[3];
        IR_L0 <= shadow[4];
        IR_L1 <= shadow[5];
        IR_L2 <= shadow[6];
        IR_L3 <= a2d.a2d_res;
      end
    end
  end

endmodule

// File: tb/tb_ir_sensor_intf.sv
// tb_ir_sensor_intf: directed bench for ir_sensor_intf with a small A2D
// responder (3 cycles after each request, result = base + channel).
module tb_ir_sensor_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        IR_en;
  logic        IR_vld;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;
  logic [11:0] ir [8];

  ir_sensor_intf_if a2d ();

  ir_sensor_intf #(
    .SETTLE_CYCLES  (4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a2d    (a2d.master),
    .IR_en  (IR_en),
    .IR_R0  (IR_R0),
    .IR_R1  (IR_R1),
    .IR_R2  (IR_R2),
    .IR_R3  (IR_R3),
    .IR_L0  (IR_L0),
    .IR_L1  (IR_L1),
    .IR_L2  (IR_L2),
    .IR_L3  (IR_L3),
    .IR_vld (IR_vld)
  );

  assign ir[0] = IR_R0;
  assign ir[1] = IR_R1;
  assign ir[2] = IR_R2;
  assign ir[3] = IR_R3;
  assign ir[4] = IR_L0;
  assign ir[5] = IR_L1;
  assign ir[6] = IR_L2;
  assign ir[7] = IR_L3;

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned cyc   = 0;
  int unsigned log_n = 0;
  int unsigned vld_n = 0;
  logic [2:0]  ch_log [512];
  logic [11:0] base  = 12'h100;
  bit          pend  = 1'b0;
  int unsigned cnt   = 0;
  logic [2:0]  pch   = '0;
  bit          spur_req = 1'b0;
  bit          pre_en;
  bit          changed;
  logic [11:0] snap [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, log requests/strobes, run the A2D model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (a2d.a2d_strt) begin
      ch_log[log_n % 512] = a2d.a2d_chnl;
      log_n++;
    end
    if (IR_vld) vld_n++;
    a2d.a2d_cnv_cmplt = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (spur_req) begin
      a2d.a2d_cnv_cmplt = 1'b1;
      a2d.a2d_res       = 12'hFFF;
      spur_req          = 1'b0;
    end else if (a2d.a2d_strt) begin
      pend = 1'b1;
      cnt  = 3;
      pch  = a2d.a2d_chnl;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        a2d.a2d_cnv_cmplt = 1'b1;
        a2d.a2d_res       = base + 12'(pch);
        pend              = 1'b0;
      end
    end
  endtask

  task automatic wait_en(input string tag, input int unsigned max_cyc);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < max_cyc; i++) begin
      step();
      if (IR_en) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_en_rise"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_strt(input string tag, input logic [2:0] ch, input int unsigned max_cyc);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < max_cyc; i++) begin
      step();
      if (a2d.a2d_strt && a2d.a2d_chnl == ch) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_strt_seen"}, 32'(ok), 32'd1);
  endtask

  // Runs until IR_vld; flags any IR_* change before the strobe.
  task automatic wait_vld(input string tag, input int unsigned max_cyc);
    bit ok = 1'b0;
    changed = 1'b0;
    for (int j = 0; j < 8; j++) snap[j] = ir[j];
    for (int unsigned i = 0; i < max_cyc; i++) begin
      pre_en = IR_en;
      step();
      if (IR_vld) begin
        ok = 1'b1;
        break;
      end
      for (int j = 0; j < 8; j++) if (ir[j] !== snap[j]) changed = 1'b1;
    end
    check({tag, "_vld_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_ir(input string tag, input logic [11:0] b);
    for (int j = 0; j < 8; j++)
      check($sformatf("%s_ir%0d", tag, j), 32'(ir[j]), 32'(b + 12'(j)));
  endtask

  task automatic check_log(input string tag, input int unsigned ls);
    check({tag, "_nreq"}, log_n - ls, 32'd8);
    for (int unsigned j = 0; j < 8; j++)
      check($sformatf("%s_req%0d", tag, j), 32'(ch_log[(ls + j) % 512]), j);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ls;
    int unsigned t_en;
    int unsigned t_vld;
    int unsigned v0;
    bit en_seen;

    rst = 1'b1;
    en  = 1'b0;
    a2d.a2d_cnv_cmplt = 1'b0;
    a2d.a2d_res       = '0;
    repeat (3) step();
    rst = 1'b0;

    // reset values, en held low
    for (int unsigned i = 0; i < 50; i++) step();
    check("rst_ir_en", 32'(IR_en), 32'd0);
    check("rst_vld_cnt", vld_n, 32'd0);
    check("rst_strt_cnt", log_n, 32'd0);
    check("rst_chnl", 32'(a2d.a2d_chnl), 32'd0);
    for (int j = 0; j < 8; j++) check($sformatf("rst_ir%0d", j), 32'(ir[j]), 32'd0);

    // single sweep
    base = 12'h100;
    ls = log_n;
    en = 1'b1;
    wait_en("s1", 5);
    t_en = cyc;
    en = 1'b0;
    wait_strt("s1", 3'd0, 20);
    check("s1_settle_lat", cyc - t_en, 32'd4);
    wait_vld("s1", 200);
    t_vld = cyc;
    check("s1_en_fall", 32'(IR_en), 32'd0);
    check("s1_en_before_vld", 32'(pre_en), 32'd1);
    check_ir("s1", 12'h100);
    check_log("s1", ls);
    en   = 1'b1;
    base = 12'hA00;
    step();
    check("s1_vld_one_cycle", 32'(IR_vld), 32'd0);

    // back-to-back sweep with en held high
    ls = log_n;
    wait_en("s2", 20);
    check("s2_restart_gap", cyc - t_vld, 32'd9);
    wait_vld("s2", 200);
    check("s2_held_until_vld", 32'(changed), 32'd0);
    check_ir("s2", 12'hA00);
    check_log("s2", ls);
    base = 12'h300;

    // en dropped during channel 3
    wait_en("s3", 20);
    wait_strt("s3", 3'd3, 100);
    en = 1'b0;
    wait_vld("s3", 200);
    t_vld = cyc;
    check_ir("s3", 12'h300);
    en_seen = 1'b0;
    ls = log_n;
    for (int unsigned i = 0; i < 30; i++) begin
      step();
      if (IR_en) en_seen = 1'b1;
    end
    check("s3_no_restart", 32'(en_seen), 32'd0);
    check("s3_no_req", log_n - ls, 32'd0);

    // spurious completes in SETTLE and HOLD
    base = 12'h400;
    en = 1'b1;
    wait_en("s4", 5);
    check("s4_holdoff_ok", 32'(cyc - t_vld >= 8), 32'd1);
    en = 1'b0;
    spur_req = 1'b1;
    step();
    v0 = vld_n;
    wait_vld("s4", 200);
    check_ir("s4", 12'h400);
    spur_req = 1'b1;
    repeat (3) step();
    check_ir("s4_hold", 12'h400);
    check("s4_single_vld", vld_n - v0, 32'd1);
    repeat (10) step();

    // reset mid-sweep after channel 5 completes
    base = 12'h500;
    en = 1'b1;
    wait_strt("s5", 3'd6, 200);
    rst = 1'b1;
    #1;
    check("s5_rst_ir_en", 32'(IR_en), 32'd0);
    check("s5_rst_strt", 32'(a2d.a2d_strt), 32'd0);
    check("s5_rst_chnl", 32'(a2d.a2d_chnl), 32'd0);
    check("s5_rst_vld", 32'(IR_vld), 32'd0);
    for (int j = 0; j < 8; j++) check($sformatf("s5_rst_ir%0d", j), 32'(ir[j]), 32'd0);
    repeat (2) step();
    rst  = 1'b0;
    base = 12'h600;
    ls = log_n;
    wait_en("s6", 5);
    en = 1'b0;
    wait_vld("s6", 200);
    check_ir("s6", 12'h600);
    check_log("s6", ls);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
